// File: rtl/mem_access_unit_if.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : mem_access_unit_if
//  Description : Data-memory port bundle between the load/store unit and a
//                word-organised data memory.
//                  addr     - word address
//                  data_in  - lane-replicated store data
//                  str      - write strobe
//                  sel      - byte-lane select, bit n covers bits [8n+7:8n]
//                  ld       - read enable
//                  data_out - registered, lane-masked read data
//                Modports: master = access unit, slave = memory.
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int MEM_ADDR_BITS = 20
) ();
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [31:0]              data_in;
    logic                     str;
    logic [3:0]               sel;
    logic                     ld;
    logic [31:0]              data_out;

    modport master (
        output addr, data_in, str, sel, ld,
        input  data_out
    );

    modport slave (
        input  addr, data_in, str, sel, ld,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : mem_access_unit
//  Description : Load/store controller between the CPU MEM stage and a
//                word-organised data memory. Turns byte/half/word requests at
//                byte addresses into word address + lane select + replicated
//                store data, and extracts/extends load data. Misaligned or
//                illegal-size requests fault without touching memory.
//  Ports       : clk, clr (sync active-high reset)
//                req/we/size/sign_ext/addr/wdata - CPU request
//                busy/done/err/rdata             - CPU status and result
//                mem                             - data-memory port (master)
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MEM_ADDR_BITS = 20
) (
    input  wire logic                     clk,
    input  wire logic                     clr,
    input  wire logic                     req,
    input  wire logic                     we,
    input  wire logic [1:0]               size,
    input  wire logic                     sign_ext,
    input  wire logic [MEM_ADDR_BITS+1:0] addr,
    input  wire logic [31:0]              wdata,
    output      logic                     busy,
    output      logic                     done,
    output      logic                     err,
    output      logic [31:0]              rdata,
    mem_access_unit_if.master             mem
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_next;

    logic                     r_we;
    logic [1:0]               r_size;
    logic                     r_sign_ext;
    logic [MEM_ADDR_BITS+1:0] r_addr;
    logic [31:0]              r_wdata;
    logic                     r_done;
    logic                     r_err;
    logic [31:0]              r_rdata;

    logic                     w_misaligned;
    logic                     w_str;
    logic                     w_ld;
    logic [3:0]               w_sel;
    logic [31:0]              w_din;
    logic [31:0]              w_shift;
    logic [31:0]              w_load;

    // Checked on the live inputs so the fault decision is made at acceptance.
    always_comb begin
        w_misaligned = 1'b0;
        case (size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = addr[0];
            2'b10:   w_misaligned = (addr[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and memory pins; pins are live only during ISSUE.
    always_comb begin
        w_next = r_state;
        w_str  = 1'b0;
        w_ld   = 1'b0;
        w_sel  = 4'b0000;
        w_din  = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_next = w_misaligned ? ST_FAULT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_RESP;
                w_str  = r_we;
                w_ld   = !r_we;
                case (r_size)
                    2'b00: begin
                        w_sel = 4'b0001 << r_addr[1:0];
                        w_din = {4{r_wdata[7:0]}};
                    end
                    2'b01: begin
                        w_sel = r_addr[1] ? 4'b1100 : 4'b0011;
                        w_din = {2{r_wdata[15:0]}};
                    end
                    default: begin
                        // Only word reaches here; size 11 always faults.
                        w_sel = 4'b1111;
                        w_din = r_wdata;
                    end
                endcase
            end
            ST_RESP:  w_next = ST_IDLE;
            ST_FAULT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Memory returns the lanes in place; shift the addressed lane down to bit 0.
    always_comb begin
        w_shift = mem.data_out >> {r_addr[1:0], 3'b000};
        w_load  = w_shift;
        case (r_size)
            2'b00:   w_load = {{24{r_sign_ext & w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_load = {{16{r_sign_ext & w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    // Request latch and response registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 32'h0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (r_state == ST_IDLE && req) begin
                r_we       <= we;
                r_size     <= size;
                r_sign_ext <= sign_ext;
                r_addr     <= addr;
                r_wdata    <= wdata;
            end
            if (r_state == ST_RESP) begin
                r_done  <= 1'b1;
                r_rdata <= r_we ? 32'h0 : w_load;
            end
            if (r_state == ST_FAULT) begin
                r_done  <= 1'b1;
                r_err   <= 1'b1;
                r_rdata <= 32'h0;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign mem.addr    = r_addr[MEM_ADDR_BITS+1:2];
    assign mem.data_in = w_din;
    assign mem.str     = w_str;
    assign mem.sel     = w_sel;
    assign mem.ld      = w_ld;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : tb_mem_access_unit
//  Description : Scoreboard bench for mem_access_unit with a small registered,
//                lane-masked word memory model. Issue-cycle pin values and
//                done/err/rdata responses are queued when stimulus is sent and
//                popped by an independent negedge monitor.
//  Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_mem_access_unit;
    localparam int MEM_ADDR_BITS = 20;

    logic                     clk = 1'b0;
    logic                     clr;
    logic                     req;
    logic                     we;
    logic [1:0]               size;
    logic                     sign_ext;
    logic [MEM_ADDR_BITS+1:0] addr;
    logic [31:0]              wdata;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [31:0]              rdata;

    mem_access_unit_if #(.MEM_ADDR_BITS(MEM_ADDR_BITS)) mif ();

    mem_access_unit #(.MEM_ADDR_BITS(MEM_ADDR_BITS)) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem      (mif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [3:0]  sel;
        logic [31:0] din;
        logic        str;
        logic        ld;
    } issue_t;

    resp_t  resp_q[$];
    issue_t issue_q[$];
    int     n_vec = 0;
    int     n_bad = 0;

    // Memory model: registered read, output masked to selected lanes.
    logic [31:0] mem_words [0:63];

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem_words[i] = 32'h0;
        mif.data_out = 32'h0;
    end

    always @(posedge clk) begin
        if (mif.ld) mif.data_out <= mem_words[mif.addr[5:0]] & lane_mask(mif.sel);
        if (mif.str) begin
            for (int i = 0; i < 4; i++)
                if (mif.sel[i]) mem_words[mif.addr[5:0]][8*i +: 8] <= mif.data_in[8*i +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop expectations whenever the DUT presents a strobe or a done.
    always @(negedge clk) begin
        if (mif.str === 1'b1 || mif.ld === 1'b1) begin
            n_vec++;
            if (issue_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_strobe: got addr=%h sel=%b din=%h str=%b ld=%b, expected none",
                         mif.addr, mif.sel, mif.data_in, mif.str, mif.ld);
            end else begin
                issue_t e;
                issue_t a;
                e = issue_q.pop_front();
                a = '{addr: mif.addr, sel: mif.sel, din: mif.data_in, str: mif.str, ld: mif.ld};
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL issue_pins: got addr=%h sel=%b din=%h str=%b ld=%b, expected addr=%h sel=%b din=%h str=%b ld=%b",
                             a.addr, a.sel, a.din, a.str, a.ld, e.addr, e.sel, e.din, e.str, e.ld);
                end
            end
        end
        if (done === 1'b1) begin
            n_vec++;
            if (resp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: got err=%b rdata=%h, expected no done", err, rdata);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                if (err !== e.err || rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL response: got err=%b rdata=%h, expected err=%b rdata=%h",
                             err, rdata, e.err, e.rdata);
                end
            end
        end
    end

    // One request from an idle unit; expectations queued before it is sent.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [21:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd,
                          input logic [3:0] e_sel, input logic [31:0] e_din);
        resp_q.push_back('{err: e_err, rdata: e_rd});
        if (!e_err) issue_q.push_back('{addr: a[21:2], sel: e_sel, din: e_din, str: w, ld: !w});
        we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (e_err ? 1 : 2) @(posedge clk);
        #1;
        check("done_latency", {31'h0, done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'h0, busy},     32'h0);
        check("rst_done",  {31'h0, done},     32'h0);
        check("rst_err",   {31'h0, err},      32'h0);
        check("rst_rdata", rdata,             32'h0);
        check("rst_str",   {31'h0, mif.str},  32'h0);
        check("rst_ld",    {31'h0, mif.ld},   32'h0);
        check("rst_sel",   {28'h0, mif.sel},  32'h0);
        check("rst_din",   mif.data_in,       32'h0);
        check("rst_addr",  {12'h0, mif.addr}, 32'h0);
        clr = 1'b0;
        @(posedge clk); #1;

        // Word store/load
        do_req(1, 2'b10, 0, 22'h10, 32'hDEADBEEF, 0, 32'h0,        4'b1111, 32'hDEADBEEF);
        do_req(0, 2'b10, 0, 22'h10, 32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h0);
        // Byte store into top lane, signed/unsigned reload
        do_req(1, 2'b00, 0, 22'h13, 32'h00000080, 0, 32'h0,        4'b1000, 32'h80808080);
        do_req(0, 2'b00, 1, 22'h13, 32'h0,        0, 32'hFFFFFF80, 4'b1000, 32'h0);
        do_req(0, 2'b00, 0, 22'h13, 32'h0,        0, 32'h00000080, 4'b1000, 32'h0);
        do_req(0, 2'b10, 0, 22'h10, 32'h0,        0, 32'h80ADBEEF, 4'b1111, 32'h0);
        // Half store into upper half; word is now 8001BEEF
        do_req(1, 2'b01, 0, 22'h12, 32'h00008001, 0, 32'h0,        4'b1100, 32'h80018001);
        do_req(0, 2'b01, 1, 22'h12, 32'h0,        0, 32'hFFFF8001, 4'b1100, 32'h0);
        do_req(0, 2'b01, 0, 22'h12, 32'h0,        0, 32'h00008001, 4'b1100, 32'h0);
        do_req(0, 2'b01, 1, 22'h10, 32'h0,        0, 32'hFFFFBEEF, 4'b0011, 32'h0);
        do_req(0, 2'b00, 1, 22'h11, 32'h0,        0, 32'hFFFFFFBE, 4'b0010, 32'h0);
        do_req(0, 2'b00, 0, 22'h10, 32'h0,        0, 32'h000000EF, 4'b0001, 32'h0);
        // Faults: no strobes expected, rdata cleared
        do_req(0, 2'b10, 0, 22'h11, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
        do_req(0, 2'b01, 0, 22'h13, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
        do_req(0, 2'b11, 0, 22'h10, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
        do_req(1, 2'b01, 0, 22'h11, 32'h12345678, 1, 32'h0,        4'b0000, 32'h0);
        do_req(0, 2'b10, 0, 22'h10, 32'h0,        0, 32'h8001BEEF, 4'b1111, 32'h0);

        // req held high with alternating addresses: accepted at cycles 0, 3, 6
        resp_q.push_back('{err: 1'b0, rdata: 32'h0000BEEF});
        issue_q.push_back('{addr: 20'h4, sel: 4'b0011, din: 32'h0, str: 1'b0, ld: 1'b1});
        resp_q.push_back('{err: 1'b0, rdata: 32'h00008001});
        issue_q.push_back('{addr: 20'h4, sel: 4'b1100, din: 32'h0, str: 1'b0, ld: 1'b1});
        resp_q.push_back('{err: 1'b0, rdata: 32'h0000BEEF});
        issue_q.push_back('{addr: 20'h4, sel: 4'b0011, din: 32'h0, str: 1'b0, ld: 1'b1});
        we = 1'b0; size = 2'b01; sign_ext = 1'b0; wdata = 32'h0;
        for (int k = 0; k < 9; k++) begin
            addr = (k % 2 == 1) ? 22'h12 : 22'h10;
            req  = 1'b1;
            @(posedge clk); #1;
        end
        req = 1'b0;
        check("held_req_last_done", {31'h0, done}, 32'h1);

        // clr during RESP of a load: no done, result cleared
        issue_q.push_back('{addr: 20'h4, sel: 4'b1111, din: 32'h0, str: 1'b0, ld: 1'b1});
        we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 22'h10; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_busy",  {31'h0, busy}, 32'h0);
        check("clr_done",  {31'h0, done}, 32'h0);
        check("clr_err",   {31'h0, err},  32'h0);
        check("clr_rdata", rdata,         32'h0);
        do_req(0, 2'b10, 0, 22'h10, 32'h0, 0, 32'h8001BEEF, 4'b1111, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("resp_queue_empty",  resp_q.size(),  32'h0);
        check("issue_queue_empty", issue_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store controller that drives the word-organised data memory's port: addr, data_in, str, sel, ld, and data_out.
- Sits between the CPU MEM stage and the data memory.
- Converts byte-addressed byte/half/word requests into word address, byte-lane select and replicated store data.
- Extracts and sign/zero-extends load data from the memory's registered, lane-masked output.
- Flags misaligned or illegal-size accesses without touching memory.

Parameters:
MEM_ADDR_BITS, 20, word-address width of the data memory; byte address is MEM_ADDR_BITS+2 bits.

Ports:
clk  input  1  clock, rising edge
clr  input  1  synchronous active-high reset
req  input  1  request strobe; sampled only when busy=0
we  input  1  1=store, 0=load
size  input  2  00 byte, 01 half, 10 word, 11 illegal
sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend
addr  input  MEM_ADDR_BITS+2  byte address
wdata  input  32  store data, right-justified
busy  output  1  unit not idle
done  output  1  one-cycle completion pulse
err  output  1  valid with done; misaligned or illegal size
rdata  output  32  extended load result; held until next done
mem_addr  output  MEM_ADDR_BITS  word address to memory
mem_data_in  output  32  lane-replicated store data
mem_str  output  1  memory write strobe
mem_sel  output  4  byte-lane select; bit n = bits [8n+7:8n]
mem_ld  output  1  memory read enable
mem_data_out  input  32  memory read data, registered, lane-masked

Behaviour:
- Little-endian lanes. off = addr[1:0]. mem_addr = latched addr[MEM_ADDR_BITS+1:2].
- States: IDLE, ISSUE, RESP, FAULT. Inputs are latched on acceptance. busy = (state != IDLE).
- IDLE:
  - req=1 and aligned → ISSUE.
  - req=1 and misaligned → FAULT. Misaligned means half with off[0]=1, word with off!=0, or size=11.
  - req=0 → stay in IDLE.
- ISSUE (exactly one cycle): memory pins driven from the latched request; next state RESP.
  - mem_ld = !we_r.
  - mem_str = we_r.
  - mem_sel:
    - byte: 1<<off
    - half: off=0 → 0011, off=2 → 1100
    - word: 1111
  - mem_data_in:
    - byte: {4{wdata[7:0]}}
    - half: {2{wdata[15:0]}}
    - word: wdata
- Outside ISSUE: mem_str=0, mem_ld=0, mem_sel=0000, mem_data_in=0. mem_addr keeps the latched value.
- RESP: at the closing edge, state → IDLE and done←1, err←0.
  - Load: rdata ← extend(mem_data_out >> (8*off)) from bit 7 (byte), bit 15 (half) or 31 (word), using sign_ext_r.
  - Store: rdata ← 0.
- FAULT: at the closing edge, done←1, err←1, rdata←0, state → IDLE. mem_str and mem_ld are never asserted for a faulting request.
- Latency:
  - Accepted at edge E0; memory samples at E1; done=1 in the cycle after E2.
  - Faults: done=1 in the cycle after E1.
- done and err are single-cycle pulses. done is set only on transition to IDLE, so a req in the done cycle is accepted (back-to-back, one access per 3 cycles).
- req while busy=1 is ignored and not queued.
- clr: next edge forces IDLE, busy=0, done=0, err=0, rdata=0 and all memory pins deasserted. clr during ISSUE means the memory still sees that edge's strobe; no further strobes follow. The memory's own clear is not driven by this block.
- Reset values: busy 0, done 0, err 0, rdata 0, mem_str 0, mem_ld 0, mem_sel 0, mem_data_in 0, mem_addr 0.

Test Plan:
1. Store word 0xDEADBEEF at addr 0x10 → ISSUE cycle shows mem_addr=4, mem_sel=1111, mem_str=1, mem_ld=0. done 2 cycles after acceptance, err=0. Load word 0x10 → rdata=0xDEADBEEF.
2. Store byte 0x80 at 0x13 → mem_sel=1000, mem_data_in=0x80808080. Load byte 0x13 with sign_ext=1 → 0xFFFFFF80; with sign_ext=0 → 0x00000080. Bytes 0x10–0x12 unchanged (reload word → 0x80ADBEEF).
3. Store half 0x8001 at 0x12 → mem_sel=1100, mem_data_in=0x80018001. Signed half load → 0xFFFF8001; unsigned → 0x00008001.
4. Load word at 0x11, half at 0x13, size=11 at 0x10 → each gives done=err=1 one cycle after acceptance and rdata=0. mem_ld and mem_str stay 0 throughout.
5. req held high continuously with alternating addresses → accepted only in IDLE cycles (every 3rd cycle). req pulses during ISSUE/RESP produce no extra done.
6. clr asserted during RESP of a load → next cycle busy=0, done=0, rdata=0. Subsequent load returns correct data with no stale done.
